// File: rtl/gray_counter_ud.sv
// Up/down Gray-code counter: binary state register with a separately registered
// Gray output, parallel load (binary or Gray), wrap/saturate limits and strobes.
module gray_counter_ud #(
  parameter int          DATA_WIDTH  = 4,
  parameter int          SATURATE    = 0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic                  load_gray,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  tc,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  changed
);

  localparam logic [DATA_WIDTH-1:0] MAX_B = '1;
  localparam logic [DATA_WIDTH-1:0] ONE_B = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] RST_B = RESET_VALUE[DATA_WIDTH-1:0];

  function automatic logic [DATA_WIDTH-1:0] bin2gray(input logic [DATA_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] b;
    b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] r_bin;
  logic [DATA_WIDTH-1:0] r_gray;
  logic                  r_tc;
  logic                  r_changed;

  logic [DATA_WIDTH-1:0] w_bin_next;
  logic [DATA_WIDTH-1:0] w_gray_next;
  logic                  w_wrap;
  logic                  w_changed_next;

  always_comb begin
    w_bin_next = r_bin;
    w_wrap     = 1'b0;
    if (load) begin
      w_bin_next = load_gray ? gray2bin(load_val) : load_val;
    end else if (en) begin
      if (up) begin
        if (r_bin != MAX_B) begin
          w_bin_next = r_bin + ONE_B;
        end else if (SATURATE == 0) begin
          w_bin_next = '0;
          w_wrap     = 1'b1;
        end
      end else begin
        if (r_bin != '0) begin
          w_bin_next = r_bin - ONE_B;
        end else if (SATURATE == 0) begin
          w_bin_next = MAX_B;
          w_wrap     = 1'b1;
        end
      end
    end
    w_gray_next    = bin2gray(w_bin_next);
    // A hold (including a saturated step or reloading the same value) leaves the code unchanged.
    w_changed_next = (w_gray_next != r_gray);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin     <= RST_B;
      r_gray    <= bin2gray(RST_B);
      r_tc      <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_bin     <= w_bin_next;
      r_gray    <= w_gray_next;
      r_tc      <= w_wrap;
      r_changed <= w_changed_next;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign tc       = r_tc;
  assign changed  = r_changed;
  assign at_max   = (r_bin == MAX_B);
  assign at_min   = (r_bin == '0);

endmodule

// File: tb/tb_gray_counter_ud.sv
// Directed bench for gray_counter_ud: 4-bit wrap and saturate instances plus
// 2-bit and 8-bit instances for the width sweep, all sharing the control inputs.
module tb_gray_counter_ud;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, up, load, load_gray;
  logic [3:0] lv4;
  logic [1:0] lv2;
  logic [7:0] lv8;

  logic [3:0] g4, b4, gs, bs;
  logic [1:0] g2, b2;
  logic [7:0] g8, b8;
  logic tc4, mx4, mn4, ch4;
  logic tcs, mxs, mns, chs;
  logic tc2, mx2, mn2, ch2;
  logic tc8, mx8, mn8, ch8;

  int checks = 0;
  int failures = 0;

  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_counter_ud #(.DATA_WIDTH(4), .SATURATE(0), .RESET_VALUE(0)) dut4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(lv4), .gray_out(g4), .bin_out(b4), .tc(tc4), .at_max(mx4),
    .at_min(mn4), .changed(ch4));

  gray_counter_ud #(.DATA_WIDTH(4), .SATURATE(1), .RESET_VALUE(0)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(lv4), .gray_out(gs), .bin_out(bs), .tc(tcs), .at_max(mxs),
    .at_min(mns), .changed(chs));

  gray_counter_ud #(.DATA_WIDTH(2), .SATURATE(0), .RESET_VALUE(0)) dut2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(lv2), .gray_out(g2), .bin_out(b2), .tc(tc2), .at_max(mx2),
    .at_min(mn2), .changed(ch2));

  gray_counter_ud #(.DATA_WIDTH(8), .SATURATE(0), .RESET_VALUE(0)) dut8 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(lv8), .gray_out(g8), .bin_out(b8), .tc(tc8), .at_max(mx8),
    .at_min(mn8), .changed(ch8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; en = 0; up = 1; load = 0; load_gray = 0; lv4 = '0; lv2 = '0; lv8 = '0;
    tick(); tick();
    checks++; if (g4 !== 4'b0000) begin failures++; $display("FAIL reset_gray got=%b exp=0000", g4); end
    checks++; if (b4 !== 4'd0) begin failures++; $display("FAIL reset_bin got=%0d exp=0", b4); end
    checks++; if ({mn4, mx4, tc4, ch4} !== 4'b1000) begin failures++; $display("FAIL reset_flags got=%b exp=1000", {mn4, mx4, tc4, ch4}); end
    en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({g4, b4, tc4, ch4, mn4} !== {4'd0, 4'd0, 3'b001}) begin
        failures++; $display("FAIL reset_hold_en cyc=%0d got g=%b b=%0d tc=%b ch=%b mn=%b exp 0/0/0/0/1", i, g4, b4, tc4, ch4, mn4);
      end
    end
    reset = 0; en = 0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] prev;
    logic [3:0] eb;
    prev = g4;
    en = 1; up = 1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      eb = 4'(k % 16);
      checks++; if (b4 !== eb) begin failures++; $display("FAIL upwrap_bin k=%0d got=%0d exp=%0d", k, b4, eb); end
      checks++; if (g4 !== gtab[k % 16]) begin failures++; $display("FAIL upwrap_gray k=%0d got=%b exp=%b", k, g4, gtab[k % 16]); end
      checks++; if (tc4 !== (k == 16)) begin failures++; $display("FAIL upwrap_tc k=%0d got=%b exp=%b", k, tc4, (k == 16)); end
      checks++; if (ch4 !== 1'b1) begin failures++; $display("FAIL upwrap_changed k=%0d got=%b exp=1", k, ch4); end
      checks++; if ($countones(prev ^ g4) != 1) begin failures++; $display("FAIL upwrap_onebit k=%0d got=%0d exp=1", k, $countones(prev ^ g4)); end
      checks++; if ({mx4, mn4} !== {(k == 15), (k == 16)}) begin failures++; $display("FAIL upwrap_levels k=%0d got=%b exp=%b", k, {mx4, mn4}, {(k == 15), (k == 16)}); end
      prev = g4;
    end
    en = 0;
  endtask

  task automatic test_down_dir();
    logic [3:0] eb [4] = '{4'd2, 4'd1, 4'd0, 4'd15};
    logic [3:0] eg [4] = '{4'b0011, 4'b0001, 4'b0000, 4'b1000};
    logic [3:0] et [4] = '{4'd6, 4'd5, 4'd6, 4'd5};
    load = 1; load_gray = 0; lv4 = 4'd3;
    tick();
    load = 0;
    checks++; if ({b4, g4} !== {4'd3, 4'b0010}) begin failures++; $display("FAIL load_bin3 got b=%0d g=%b exp b=3 g=0010", b4, g4); end
    en = 1; up = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({b4, g4, tc4} !== {eb[i], eg[i], (i == 3)}) begin
        failures++; $display("FAIL down_step i=%0d got b=%0d g=%b tc=%b exp b=%0d g=%b tc=%b", i, b4, g4, tc4, eb[i], eg[i], (i == 3));
      end
    end
    en = 0; load = 1; lv4 = 4'd5;
    tick();
    load = 0; en = 1;
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      tick();
      checks++;
      if ({b4, tc4} !== {et[i], 1'b0}) begin
        failures++; $display("FAIL toggle_dir i=%0d got b=%0d tc=%b exp b=%0d tc=0", i, b4, tc4, et[i]);
      end
    end
    en = 0;
    tick();
    checks++; if ({b4, ch4, tc4} !== {4'd5, 2'b00}) begin failures++; $display("FAIL hold got b=%0d ch=%b tc=%b exp b=5 ch=0 tc=0", b4, ch4, tc4); end
  endtask

  task automatic test_saturate();
    load = 1; load_gray = 0; lv4 = 4'd14; en = 0;
    tick();
    load = 0; en = 1; up = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bs, gs, mxs, tcs, chs} !== {4'd15, 4'b1000, 1'b1, 1'b0, (i == 0)}) begin
        failures++; $display("FAIL sat_up i=%0d got b=%0d g=%b max=%b tc=%b ch=%b exp b=15 g=1000 max=1 tc=0 ch=%b", i, bs, gs, mxs, tcs, chs, (i == 0));
      end
    end
    en = 0; load = 1; lv4 = 4'd1;
    tick();
    load = 0; en = 1; up = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bs, gs, mns, tcs, chs} !== {4'd0, 4'b0000, 1'b1, 1'b0, (i == 0)}) begin
        failures++; $display("FAIL sat_down i=%0d got b=%0d g=%b min=%b tc=%b ch=%b exp b=0 g=0000 min=1 tc=0 ch=%b", i, bs, gs, mns, tcs, chs, (i == 0));
      end
    end
    en = 0;
  endtask

  task automatic test_gray_load();
    load = 1; load_gray = 0; lv4 = 4'd3; en = 0;
    tick();
    load_gray = 1; lv4 = 4'b1100;
    tick();
    checks++; if ({b4, g4, ch4} !== {4'd8, 4'b1100, 1'b1}) begin failures++; $display("FAIL gray_load got b=%0d g=%b ch=%b exp b=8 g=1100 ch=1", b4, g4, ch4); end
    tick();
    checks++; if ({b4, g4, ch4} !== {4'd8, 4'b1100, 1'b0}) begin failures++; $display("FAIL load_same got b=%0d g=%b ch=%b exp b=8 g=1100 ch=0", b4, g4, ch4); end
    load_gray = 0; lv4 = 4'd5; en = 1; up = 1;
    tick();
    checks++; if ({b4, g4, tc4} !== {4'd5, 4'b0111, 1'b0}) begin failures++; $display("FAIL load_beats_en got b=%0d g=%b tc=%b exp b=5 g=0111 tc=0", b4, g4, tc4); end
    load = 0;
    tick();
    checks++; if (b4 !== 4'd6) begin failures++; $display("FAIL step_after_load got=%0d exp=6", b4); end
    reset = 1; load = 1; lv4 = 4'd9;
    tick();
    checks++; if ({b4, g4, ch4} !== {4'd0, 4'b0000, 1'b0}) begin failures++; $display("FAIL reset_beats_load got b=%0d g=%b ch=%b exp b=0 g=0000 ch=0", b4, g4, ch4); end
    reset = 0; load = 0; en = 0;
    tick();
    checks++; if (b4 !== 4'd0) begin failures++; $display("FAIL post_reset_idle got=%0d exp=0", b4); end
    en = 1;
    tick();
    checks++; if (b4 !== 4'd1) begin failures++; $display("FAIL first_step got=%0d exp=1", b4); end
    en = 0;
  endtask

  task automatic test_width_sweep();
    logic [1:0] m2, p2;
    logic [7:0] m8, p8;
    bit seen2 [4];
    bit seen8 [256];
    int d2, d8;
    reset = 1; en = 0; load = 0;
    tick();
    reset = 0; en = 1; up = 1;
    m2 = '0; m8 = '0; p2 = g2; p8 = g8; d2 = 0; d8 = 0;
    for (int i = 0; i < 4; i++) seen2[i] = 0;
    for (int i = 0; i < 256; i++) seen8[i] = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      m2 = m2 + 2'd1; m8 = m8 + 8'd1;
      checks++; if (b2 !== m2 || g2 !== (b2 ^ (b2 >> 1)) || $countones(p2 ^ g2) != 1 || tc2 !== (m2 == 2'd0)) begin
        failures++; $display("FAIL sweep_w2 k=%0d got b=%0d g=%b tc=%b exp b=%0d tc=%b", k, b2, g2, tc2, m2, (m2 == 2'd0));
      end
      checks++; if (b8 !== m8 || g8 !== (b8 ^ (b8 >> 1)) || $countones(p8 ^ g8) != 1 || tc8 !== (m8 == 8'd0)) begin
        failures++; $display("FAIL sweep_w8 k=%0d got b=%0d g=%b tc=%b exp b=%0d tc=%b", k, b8, g8, tc8, m8, (m8 == 8'd0));
      end
      if (k <= 4 && !seen2[g2]) begin seen2[g2] = 1; d2++; end
      if (!seen8[g8]) begin seen8[g8] = 1; d8++; end
      p2 = g2; p8 = g8;
    end
    en = 0;
    checks++; if (d2 != 4) begin failures++; $display("FAIL sweep_w2_distinct got=%0d exp=4", d2); end
    checks++; if (d8 != 256) begin failures++; $display("FAIL sweep_w8_distinct got=%0d exp=256", d8); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_dir();
    test_saturate();
    test_gray_load();
    test_width_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_counter_ud.md
# gray_counter_ud

Parametrised up/down Gray-code counter with a registered Gray output and a matching binary shadow. It adds the following on top of a free-running Gray generator:
- Count enable and direction control.
- Parallel load in either binary or Gray encoding.
- A choice of wrap or saturate at the count limits.
- Terminal-count and change-strobe outputs.

It serves as the pointer and sequence source for clock-domain-crossing FIFOs and position encoders elsewhere in the design.

## Interface
- DATA_WIDTH, 4, counter width in bits; legal range 2..32.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
- RESET_VALUE, 0, binary value loaded on reset; must be < 2^DATA_WIDTH.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  parallel load strobe.
- load_gray  input  1  1 = load_val is Gray-encoded, 0 = binary; sampled only when load=1.
- load_val  input  DATA_WIDTH  value to load.
- gray_out  output  DATA_WIDTH  registered Gray code of the count.
- bin_out  output  DATA_WIDTH  registered binary count.
- tc  output  1  one-cycle pulse: the count wrapped on the last edge.
- at_max  output  1  level: bin_out == 2^DATA_WIDTH-1.
- at_min  output  1  level: bin_out == 0.
- changed  output  1  one-cycle pulse: gray_out changed on the last edge.

## Operation
- State is a binary register b. gray_out is a separate register, written with g(b_next) = b_next ^ (b_next >> 1) on the same edge, so it is glitch-free and carries no combinational path from inputs.
- Priority per edge: reset > load > en > hold.
- **reset=1**
  - b <= RESET_VALUE and gray_out <= g(RESET_VALUE).
  - tc <= 0 and changed <= 0.
- **load=1**
  - With load_gray=0: b <= load_val.
  - With load_gray=1: b <= gray-to-binary(load_val), where b[W-1] = v[W-1] and b[i] = b[i+1] ^ v[i].
  - tc <= 0.
  - changed <= (new gray_out != old gray_out).
- **en=1, up=1**
  - If b < MAX: b <= b+1.
  - If b == MAX and SATURATE=0: b <= 0 and tc <= 1.
  - If b == MAX and SATURATE=1: b holds, tc <= 0, changed <= 0.
- **en=1, up=0**
  - If b > 0: b <= b-1.
  - If b == 0 and SATURATE=0: b <= MAX and tc <= 1.
  - If b == 0 and SATURATE=1: b holds, tc <= 0, changed <= 0.
- **en=0, no load:** b holds, tc <= 0, changed <= 0.
- **changed on a step:** every real step (including a wrap) flips exactly one gray_out bit, and changed <= 1.
- **Arithmetic:** all arithmetic is modulo 2^DATA_WIDTH; no carry-out is exposed beyond tc.
- **Flag decode:** at_max and at_min are combinational decodes of the bin_out register, never of inputs.

## Timing
- Latency: one cycle from a sampled control (en/up/load/reset) to gray_out, bin_out, tc and changed.
- Reset values:
  - gray_out = g(RESET_VALUE) and bin_out = RESET_VALUE.
  - tc = 0 and changed = 0.
  - at_max and at_min follow RESET_VALUE (default: at_min=1, at_max=0).
- Reset asserted mid-count overrides load and en in the same cycle. The first count step after reset deasserts happens on the edge where en is sampled high.
- load and en high together: load wins and no step occurs that cycle.
- Back-to-back en: one step per cycle with no bubbles. The up input may change every cycle.
- Loading the current value: the outputs are unchanged and changed = 0.

## Test plan
- **Reset:** DATA_WIDTH=4, RESET_VALUE=0, reset 2 cycles.
  - Required: gray_out=0000, bin_out=0, at_min=1, tc=0, changed=0.
  - Then with reset=1 and en=1 for 3 cycles, the outputs stay at reset values.
- **Up-wrap:** en=1, up=1 for 17 cycles from 0.
  - gray_out steps 0000, 0001, 0011, 0010, ..., 1000, then 0000, with exactly one bit flipped per cycle.
  - tc=1 only on the 0000 after 1000; changed=1 every cycle.
- **Down and direction:** load binary 3, then up=0 for 4 cycles.
  - bin_out goes 2, 1, 0, 15 and gray_out goes 0011, 0001, 0000, 1000; tc pulses once.
  - Toggling up every cycle makes bin_out alternate between two adjacent values.
- **Saturate:** SATURATE=1, load 14, then en=1, up=1 for 3 cycles.
  - bin_out goes 15, 15, 15 with at_max=1 from the first cycle; tc=0 throughout.
  - changed=1, 0, 0.
  - Mirror check: from 1 with down for 3 cycles, bin_out goes 0, 0, 0.
- **Gray load:** load_gray=1, load_val=1100.
  - bin_out=8 and gray_out=1100 next cycle; changed=1 if the previous value differed.
  - load and en together in the same cycle: the load value wins and there is no step.
- **Width sweep:** DATA_WIDTH=2 and DATA_WIDTH=8, full up-cycle in each.
  - Exactly 2^W distinct gray_out values, a single-bit Hamming distance between consecutive values including the wrap, and gray_out == bin_out ^ (bin_out>>1) on every cycle.
